// File: rtl/inst_prefetch_arbiter.sv
// Instruction-side memory read port arbiter.
// Demand fills share the port with a single-entry next-line prefetcher.
module inst_prefetch_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 256,
  parameter int LINE_BYTES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pf_en,
  input  logic              flush,
  input  logic              dmd_req,
  input  logic [ADDR_W-1:0] dmd_addr,
  output logic              dmd_resp,
  output logic [LINE_W-1:0] dmd_rdata,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [31:0]       pf_hits
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(LINE_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN  = ~(STRIDE - ADDR_W'(1));

  typedef enum logic [1:0] {
    IDLE,
    DMD_RD,
    PF_RD,
    RESP
  } state_t;

  state_t state, state_d;

  logic              buf_valid, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr, buf_addr_d;
  logic [LINE_W-1:0] buf_data, buf_data_d;
  logic              pf_pending, pf_pending_d;
  logic [ADDR_W-1:0] pf_addr, pf_addr_d;
  logic              pf_drop, pf_drop_d;
  logic              mem_read_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [LINE_W-1:0] dmd_rdata_d;
  logic [31:0]       pf_hits_d;

  logic [ADDR_W-1:0] dmd_line;
  logic [ADDR_W-1:0] dmd_next;
  logic [ADDR_W-1:0] fill_next;
  logic              hit;

  assign dmd_line  = dmd_addr & ALIGN;
  assign dmd_next  = (dmd_line + STRIDE) & ALIGN;
  assign fill_next = (mem_addr + STRIDE) & ALIGN;

  // A same-cycle flush makes the buffer look empty to the demand.
  assign hit = dmd_req && buf_valid && !flush
            && (buf_addr == dmd_line);

  assign dmd_resp = (state == RESP);

  always_comb begin
    state_d      = state;
    buf_valid_d  = buf_valid;
    buf_addr_d   = buf_addr;
    buf_data_d   = buf_data;
    pf_pending_d = pf_pending;
    pf_addr_d    = pf_addr;
    pf_drop_d    = pf_drop;
    mem_read_d   = mem_read;
    mem_addr_d   = mem_addr;
    dmd_rdata_d  = dmd_rdata;
    pf_hits_d    = pf_hits;

    unique case (state)
      IDLE: begin
        if (flush) begin
          buf_valid_d  = 1'b0;
          pf_pending_d = 1'b0;
        end
        if (hit) begin
          dmd_rdata_d = buf_data;
          buf_valid_d = 1'b0;
          if (pf_hits != '1) begin
            pf_hits_d = pf_hits + 32'd1;
          end
          if (pf_en) begin
            pf_pending_d = 1'b1;
            pf_addr_d    = dmd_next;
          end
          state_d = RESP;
        end else if (dmd_req) begin
          mem_read_d = 1'b1;
          mem_addr_d = dmd_line;
          state_d    = DMD_RD;
        end else if (pf_pending && pf_en && !flush) begin
          mem_read_d = 1'b1;
          mem_addr_d = pf_addr;
          state_d    = PF_RD;
        end
      end

      DMD_RD: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          dmd_rdata_d = mem_rdata;
          state_d     = RESP;
          if (pf_en && (!buf_valid || buf_addr != fill_next)) begin
            pf_pending_d = 1'b1;
            pf_addr_d    = fill_next;
          end
        end
        if (flush) begin
          buf_valid_d  = 1'b0;
          pf_pending_d = 1'b0;
        end
      end

      PF_RD: begin
        if (flush) begin
          pf_drop_d   = 1'b1;
          buf_valid_d = 1'b0;
        end
        // In-flight prefetch always completes; flush only discards its data.
        if (mem_resp) begin
          mem_read_d = 1'b0;
          if (!pf_drop && !flush) begin
            buf_data_d  = mem_rdata;
            buf_addr_d  = pf_addr;
            buf_valid_d = 1'b1;
          end
          pf_pending_d = 1'b0;
          pf_drop_d    = 1'b0;
          state_d      = IDLE;
        end
      end

      RESP: begin
        if (flush) begin
          buf_valid_d  = 1'b0;
          pf_pending_d = 1'b0;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      buf_valid  <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      pf_pending <= 1'b0;
      pf_addr    <= '0;
      pf_drop    <= 1'b0;
      mem_read   <= 1'b0;
      mem_addr   <= '0;
      dmd_rdata  <= '0;
      pf_hits    <= '0;
    end else begin
      state      <= state_d;
      buf_valid  <= buf_valid_d;
      buf_addr   <= buf_addr_d;
      buf_data   <= buf_data_d;
      pf_pending <= pf_pending_d;
      pf_addr    <= pf_addr_d;
      pf_drop    <= pf_drop_d;
      mem_read   <= mem_read_d;
      mem_addr   <= mem_addr_d;
      dmd_rdata  <= dmd_rdata_d;
      pf_hits    <= pf_hits_d;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_arbiter.sv
// Bench for inst_prefetch_arbiter: memory responder, transaction-level
// scoreboard checked every cycle, and directed scenarios.
module tb_inst_prefetch_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         pf_en;
  logic         flush;
  logic         dmd_req;
  logic [31:0]  dmd_addr;
  logic         dmd_resp;
  logic [255:0] dmd_rdata;
  logic         mem_read;
  logic [31:0]  mem_addr;
  logic [255:0] mem_rdata;
  logic         mem_resp;
  logic [31:0]  pf_hits;

  inst_prefetch_arbiter #(
    .ADDR_W(32),
    .LINE_W(256),
    .LINE_BYTES(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pf_en(pf_en),
    .flush(flush),
    .dmd_req(dmd_req),
    .dmd_addr(dmd_addr),
    .dmd_resp(dmd_resp),
    .dmd_rdata(dmd_rdata),
    .mem_read(mem_read),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .mem_resp(mem_resp),
    .pf_hits(pf_hits)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name,
                       input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Memory contents: every line is a fixed function of its address.
  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) begin
      l[i*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(i + 1));
    end
    return l;
  endfunction

  // Memory responder
  bit auto_resp  = 1'b1;
  int resp_delay = 5;
  int wcnt       = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (auto_resp) begin
      mem_resp = 1'b0;
      if (mem_read) begin
        if (wcnt >= resp_delay) begin
          mem_resp  = 1'b1;
          mem_rdata = line_of(mem_addr);
          wcnt      = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Scoreboard: a demand is a buffer hit exactly when no memory read
  // starts while it is outstanding; returned data must match memory.
  int          ncyc        = 0;
  int          last_mresp  = 0;
  int          reads_total = 0;
  logic [31:0] last_read   = '0;
  int          model_hits  = 0;
  bit          dmd_open    = 1'b0;
  logic [31:0] open_addr   = '0;
  int          win_reads   = 0;
  bit          prev_read   = 1'b0;
  logic [31:0] prev_addr   = '0;
  bit          prev_dresp  = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      model_hits = 0;
      dmd_open   = 1'b0;
      prev_read  = 1'b0;
      prev_dresp = 1'b0;
    end else begin
      if (mem_resp) last_mresp = ncyc;
      if (mem_read) begin
        check("mem_align", 256'(mem_addr[4:0]), 256'(0));
        if (prev_read) begin
          check("mem_hold", 256'(mem_addr), 256'(prev_addr));
        end else begin
          reads_total++;
          last_read = mem_addr;
          if (dmd_open) win_reads++;
        end
      end
      if (dmd_resp) begin
        check("resp_has_req", 256'(dmd_open), 256'(1));
        check("resp_pulse", 256'(prev_dresp), 256'(0));
        if (dmd_open) begin
          check("resp_data", dmd_rdata, line_of(open_addr));
          if (win_reads == 0) model_hits++;
          dmd_open = 1'b0;
        end
      end else if (dmd_req && !dmd_open) begin
        dmd_open  = 1'b1;
        open_addr = dmd_addr;
        win_reads = 0;
      end
      check("pf_hits", 256'(pf_hits), 256'(model_hits));
      prev_read  = mem_read;
      prev_addr  = mem_addr;
      prev_dresp = dmd_resp;
    end
  end

  int resp_cyc;

  task automatic do_dmd(input logic [31:0] a, input bit f,
                        output int lat);
    int start;
    @(posedge clk);
    #1;
    dmd_addr = a;
    dmd_req  = 1'b1;
    flush    = f;
    start    = ncyc;
    lat      = -1;
    if (f) begin
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (dmd_resp) begin
        lat      = ncyc - start;
        resp_cyc = ncyc;
        break;
      end
    end
    if (lat < 0) fail_now("dmd_timeout");
    @(posedge clk);
    #1;
    dmd_req = 1'b0;
  endtask

  task automatic wait_reads(input int n);
    for (int i = 0; i < 100 && reads_total < n; i++) begin
      @(negedge clk);
      #1;
    end
    if (reads_total < n) fail_now("read_timeout");
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 100 && mem_read; i++) begin
      @(negedge clk);
      #1;
    end
    if (mem_read) fail_now("quiet_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int lat;
  int n;
  int late;

  initial begin
    rst       = 1'b1;
    pf_en     = 1'b1;
    flush     = 1'b0;
    dmd_req   = 1'b0;
    dmd_addr  = '0;
    mem_rdata = '0;
    mem_resp  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_dmd_resp", 256'(dmd_resp), 256'(0));
    check("rst_mem_read", 256'(mem_read), 256'(0));
    check("rst_mem_addr", 256'(mem_addr), 256'(0));
    check("rst_rdata", dmd_rdata, 256'(0));
    check("rst_pf_hits", 256'(pf_hits), 256'(0));

    // Demand miss, then next-line prefetch
    n = reads_total;
    do_dmd(32'h1000, 1'b0, lat);
    check("t1_reads", 256'(reads_total), 256'(n + 1));
    check("t1_addr", 256'(last_read), 256'(32'h1000));
    check("t1_lat", 256'(resp_cyc - last_mresp), 256'(1));
    wait_reads(n + 2);
    check("t1_pf_addr", 256'(last_read), 256'(32'h1020));
    wait_quiet();

    // Buffer hit
    n = reads_total;
    do_dmd(32'h1020, 1'b0, lat);
    check("t2_lat", 256'(lat), 256'(2));
    check("t2_no_read", 256'(reads_total), 256'(n));
    check("t2_hits", 256'(pf_hits), 256'(1));
    wait_reads(n + 1);
    check("t2_pf_addr", 256'(last_read), 256'(32'h1040));

    // Demand during in-flight prefetch waits; buffer keeps the prefetch
    pf_en = 1'b0;
    do_dmd(32'h2000, 1'b0, lat);
    check("t3_reads", 256'(reads_total), 256'(n + 2));
    check("t3_addr", 256'(last_read), 256'(32'h2000));
    n = reads_total;
    do_dmd(32'h1040, 1'b0, lat);
    check("t3_hit_lat", 256'(lat), 256'(2));
    check("t3_hits", 256'(pf_hits), 256'(2));
    repeat (5) @(negedge clk);
    #1;
    check("t3_no_pf", 256'(reads_total), 256'(n));

    // Flush during prefetch discards it
    pf_en      = 1'b1;
    resp_delay = 8;
    n = reads_total;
    do_dmd(32'h3000, 1'b0, lat);
    wait_reads(n + 2);
    check("t4_pf_addr", 256'(last_read), 256'(32'h3020));
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wait_quiet();
    n = reads_total;
    do_dmd(32'h3020, 1'b0, lat);
    check("t4_miss", 256'(reads_total), 256'(n + 1));
    check("t4_addr", 256'(last_read), 256'(32'h3020));
    check("t4_hits", 256'(pf_hits), 256'(2));
    wait_reads(n + 2);
    wait_quiet();

    // Address wrap, then prefetch disabled
    resp_delay = 3;
    n = reads_total;
    do_dmd(32'hFFFF_FFE0, 1'b0, lat);
    wait_reads(n + 2);
    check("t5_wrap", 256'(last_read), 256'(32'h0000_0000));
    wait_quiet();
    pf_en = 1'b0;
    n = reads_total;
    do_dmd(32'h5000, 1'b0, lat);
    repeat (10) @(negedge clk);
    #1;
    check("t5_no_pf", 256'(reads_total), 256'(n + 1));

    // Flush in the same cycle as a demand forces a miss
    n = reads_total;
    do_dmd(32'h0000_0000, 1'b1, lat);
    check("t5_flush_miss", 256'(reads_total), 256'(n + 1));
    check("t5_flush_addr", 256'(last_read), 256'(0));
    check("t5_hits", 256'(pf_hits), 256'(2));

    // Reset in the middle of a demand read
    auto_resp = 1'b0;
    mem_resp  = 1'b0;
    @(posedge clk);
    #1;
    dmd_addr = 32'h6000;
    dmd_req  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6_mem_read", 256'(mem_read), 256'(1));
    check("t6_mem_addr", 256'(mem_addr), 256'(32'h6000));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    dmd_req = 1'b0;
    check("t6_rst_read", 256'(mem_read), 256'(0));
    check("t6_rst_addr", 256'(mem_addr), 256'(0));
    check("t6_rst_resp", 256'(dmd_resp), 256'(0));
    check("t6_rst_rdata", dmd_rdata, 256'(0));
    check("t6_rst_hits", 256'(pf_hits), 256'(0));
    mem_rdata = line_of(32'h6000);
    mem_resp  = 1'b1;
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
    late = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (dmd_resp) late++;
    end
    check("t6_late_resp", 256'(late), 256'(0));
    check("t6_idle_read", 256'(mem_read), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
